// File: rtl/pc_gen_pkg.sv
// Shared constants and source-index enum for the PC generator.
package pc_gen_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned N_SRC_DEF = 6;
    localparam int unsigned INC_DEF   = 4;
    localparam int unsigned CNT_W_DEF = 16;

    // Redirect channel index; lower value wins arbitration.
    typedef enum logic [2:0] {
        SRC_ERET     = 3'd0,
        SRC_KERNEL   = 3'd1,
        SRC_MISSPRED = 3'd2,
        SRC_PRED     = 3'd3,
        SRC_BRANCH   = 3'd4,
        SRC_JUMP     = 3'd5
    } src_e;

endpackage

// File: rtl/pc_gen_prio_sel.sv
// Combinational priority encoder: lowest asserted index wins.
module pc_gen_prio_sel
    import pc_gen_pkg::*;
#(
    parameter int unsigned N_SRC = N_SRC_DEF,
    parameter int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] i_valid,
    output logic             o_any_c,
    output logic [IDX_W-1:0] o_idx_c
);

    // Scan from the top down so the lowest asserted index is the last write.
    always_comb begin
        o_any_c = |i_valid;
        o_idx_c = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_valid[i]) begin
                o_idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with prioritized redirects and a one-deep held slot
// for redirects that arrive while stalled.
// Optional: define PC_GEN_ALIGN_CHECK_EN to enable the sticky misaligned-target flag.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned N_SRC = N_SRC_DEF,
    parameter int unsigned INC   = INC_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [XLEN-1:0]       initial_pc,
    input  logic [N_SRC-1:0]      redir_valid,
    input  logic [N_SRC*XLEN-1:0] redir_target,
    output logic [XLEN-1:0]       pc_out,
    output logic                  pc_valid,
    output logic                  redir_pending,
    output logic [CNT_W-1:0]      redir_count,
    output logic                  misalign_fault
);

    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [XLEN-1:0]  r_pc;
    logic             r_pc_valid;
    logic             r_pend;
    logic [IDX_W-1:0] r_pend_idx;
    logic [XLEN-1:0]  r_pend_target;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any;
    logic [IDX_W-1:0] w_idx;
    logic [XLEN-1:0]  w_live_tgt;
    logic             w_live_wins;
    logic             w_load;
    logic [XLEN-1:0]  w_load_tgt;
    logic [XLEN-1:0]  w_pc_nxt;

    pc_gen_prio_sel #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_prio_sel (
        .i_valid (redir_valid),
        .o_any_c (w_any),
        .o_idx_c (w_idx)
    );

    // Target of the winning live channel.
    always_comb begin
        w_live_tgt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (IDX_W'(i) == w_idx) begin
                w_live_tgt = redir_target[i*XLEN +: XLEN];
            end
        end
    end

    // A live winner beats the held slot unless the held one has strictly higher priority.
    assign w_live_wins = w_any && (!r_pend || (w_idx <= r_pend_idx));

    // Next-PC selection: live redirect, then held redirect, then sequential.
    always_comb begin
        w_load     = 1'b0;
        w_load_tgt = '0;
        if (w_live_wins) begin
            w_load     = 1'b1;
            w_load_tgt = w_live_tgt;
        end else if (r_pend) begin
            w_load     = 1'b1;
            w_load_tgt = r_pend_target;
        end
        w_pc_nxt = w_load ? w_load_tgt : (r_pc + XLEN'(INC));
    end

    // PC, valid, held slot and redirect counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= initial_pc;
            r_pc_valid    <= 1'b0;
            r_pend        <= 1'b0;
            r_pend_idx    <= '0;
            r_pend_target <= '0;
            r_cnt         <= '0;
        end else begin
            r_pc_valid <= 1'b1;
            if (en) begin
                r_pc   <= w_pc_nxt;
                r_pend <= 1'b0;
                if (w_load && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_live_wins) begin
                r_pend        <= 1'b1;
                r_pend_idx    <= w_idx;
                r_pend_target <= w_live_tgt;
            end
        end
    end

`ifdef PC_GEN_ALIGN_CHECK_EN
    logic r_misalign;

    // Sticky flag for any loaded redirect target that is not word aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (en && w_load && (w_load_tgt[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_fault = r_misalign;
`else
    assign misalign_fault = 1'b0;
`endif

    assign pc_out        = r_pc;
    assign pc_valid      = r_pc_valid;
    assign redir_pending = r_pend;
    assign redir_count   = r_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes hand-computed expectations,
// a monitor pops one per cycle just after the active edge and compares.
module tb_pc_gen;
    import pc_gen_pkg::*;

`ifdef PC_GEN_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         en;
    logic [31:0]  initial_pc;
    logic [5:0]   redir_valid;
    logic [191:0] redir_target;
    logic [31:0]  pc_out;
    logic         pc_valid;
    logic         redir_pending;
    logic [15:0]  redir_count;
    logic         misalign_fault;

    pc_gen dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .initial_pc     (initial_pc),
        .redir_valid    (redir_valid),
        .redir_target   (redir_target),
        .pc_out         (pc_out),
        .pc_valid       (pc_valid),
        .redir_pending  (redir_pending),
        .redir_count    (redir_count),
        .misalign_fault (misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        valid;
        logic        pend;
        logic [15:0] cnt;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, id, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_out",         e.id, pc_out,                e.pc);
                chk("pc_valid",       e.id, 32'(pc_valid),         32'(e.valid));
                chk("redir_pending",  e.id, 32'(redir_pending),    32'(e.pend));
                chk("redir_count",    e.id, 32'(redir_count),      32'(e.cnt));
                chk("misalign_fault", e.id, 32'(misalign_fault),   32'(e.fault));
            end
        end
    end

    task automatic set_tgt(input int ch, input logic [31:0] val);
        redir_target[ch*32 +: 32] = val;
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input logic rst, input logic e, input logic [5:0] v,
                        input logic [31:0] xpc, input logic xvalid, input logic xpend,
                        input logic [15:0] xcnt, input logic xfault);
        exp_t x;
        reset       = rst;
        en          = e;
        redir_valid = v;
        step_id++;
        x.id = step_id; x.pc = xpc; x.valid = xvalid; x.pend = xpend;
        x.cnt = xcnt; x.fault = xfault;
        sb.push_back(x);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [5:0] bit_of(input int ch);
        logic [5:0] b;
        b = '0;
        b[ch] = 1'b1;
        return b;
    endfunction

    initial begin
        int k1, k2, k3, k4, k5, k0;
        k0 = int'(SRC_ERET);   k1 = int'(SRC_KERNEL); k2 = int'(SRC_MISSPRED);
        k3 = int'(SRC_PRED);   k4 = int'(SRC_BRANCH); k5 = int'(SRC_JUMP);
        reset = 1'b1; en = 1'b0; initial_pc = 32'h0000_1000;
        redir_valid = '0; redir_target = '0;
        @(negedge clk);
        #1;

        // Reset and sequential fetch
        step(1, 0, 6'b0, 32'h1000, 0, 0, 0, 0);
        step(1, 1, 6'b0, 32'h1000, 0, 0, 0, 0);
        step(0, 1, 6'b0, 32'h1004, 1, 0, 0, 0);
        step(0, 1, 6'b0, 32'h1008, 1, 0, 0, 0);
        step(0, 1, 6'b0, 32'h100C, 1, 0, 0, 0);

        // Simultaneous redirects: channel 1 beats channel 4
        set_tgt(k1, 32'h8000); set_tgt(k4, 32'h2000);
        step(0, 1, bit_of(k1) | bit_of(k4), 32'h8000, 1, 0, 1, 0);
        step(0, 1, 6'b0, 32'h8004, 1, 0, 1, 0);

        // Stall capture, higher-priority override, lower-priority ignored
        set_tgt(k2, 32'h3000); set_tgt(k5, 32'h7000);
        step(0, 0, bit_of(k4), 32'h8004, 1, 1, 1, 0);
        step(0, 0, bit_of(k2), 32'h8004, 1, 1, 1, 0);
        step(0, 0, bit_of(k5), 32'h8004, 1, 1, 1, 0);
        step(0, 0, 6'b0,       32'h8004, 1, 1, 1, 0);
        step(0, 1, 6'b0,       32'h3000, 1, 0, 2, 0);

        // Held channel 1 beats live channel 3, which is discarded
        set_tgt(k1, 32'h4000); set_tgt(k3, 32'h5000);
        step(0, 0, bit_of(k1), 32'h3000, 1, 1, 2, 0);
        step(0, 1, bit_of(k3), 32'h4000, 1, 0, 3, 0);
        step(0, 1, 6'b0,       32'h4004, 1, 0, 3, 0);

        // Live channel 0 beats held channel 3
        set_tgt(k0, 32'h6000);
        step(0, 0, bit_of(k3), 32'h4004, 1, 1, 3, 0);
        step(0, 1, bit_of(k0), 32'h6000, 1, 0, 4, 0);
        step(0, 1, 6'b0,       32'h6004, 1, 0, 4, 0);

        // Equal index: live target replaces held target
        step(0, 0, bit_of(k2), 32'h6004, 1, 1, 4, 0);
        set_tgt(k2, 32'h3100);
        step(0, 1, bit_of(k2), 32'h3100, 1, 0, 5, 0);
        step(0, 0, 6'b0,       32'h3100, 1, 0, 5, 0);

        // Wrap at 2^32
        set_tgt(k0, 32'hFFFF_FFFC);
        step(0, 1, bit_of(k0), 32'hFFFF_FFFC, 1, 0, 6, 0);
        step(0, 1, 6'b0,       32'h0000_0000, 1, 0, 6, 0);

        // Misaligned target is loaded unmodified; flag is sticky when enabled
        set_tgt(k0, 32'h1002);
        step(0, 1, bit_of(k0), 32'h1002, 1, 0, 7, ALIGN_EN);
        step(0, 1, 6'b0,       32'h1006, 1, 0, 7, ALIGN_EN);
        step(0, 0, bit_of(k0), 32'h1006, 1, 1, 7, ALIGN_EN);

        // Reset clears everything and drops the pending redirect
        initial_pc = 32'h0000_2000;
        step(1, 1, bit_of(k0), 32'h2000, 0, 0, 0, 0);
        step(0, 1, 6'b0,       32'h2004, 1, 0, 0, 0);

        // Counter saturation: 65534 unchecked redirects, then two checked ones
        set_tgt(k0, 32'h0000_0100);
        reset = 1'b0; en = 1'b1; redir_valid = bit_of(k0);
        for (int i = 0; i < 65534; i++) begin
            @(negedge clk);
            #1;
        end
        set_tgt(k0, 32'h0000_0200);
        step(0, 1, bit_of(k0), 32'h0200, 1, 0, 16'hFFFF, 0);
        set_tgt(k0, 32'h0000_0300);
        step(0, 1, bit_of(k0), 32'h0300, 1, 0, 16'hFFFF, 0);
        step(0, 1, 6'b0,       32'h0304, 1, 0, 16'hFFFF, 0);

        // Drain: every queued expectation must have been consumed
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: PC and target width in bits.
REQ-002 Parameter N_SRC, default 6: number of redirect channels; index 0 has highest priority.
REQ-003 Parameter INC, default 4: sequential increment; a power of two, at least 4.
REQ-004 Parameter CNT_W, default 16: width of the redirect counter.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 en  in  1  advance enable; 0 = stall, PC holds.
REQ-008 initial_pc  in  XLEN  value loaded on reset.
REQ-009 redir_valid  in  N_SRC  per-channel redirect request.
REQ-010 redir_target  in  N_SRC*XLEN  per-channel target; channel i at bits [i*XLEN +: XLEN].
REQ-011 pc_out  out  XLEN  registered current PC.
REQ-012 pc_valid  out  1  registered; pc_out holds a fetchable PC.
REQ-013 redir_pending  out  1  registered; a captured redirect awaits application.
REQ-014 redir_count  out  CNT_W  registered count of applied redirects.
REQ-015 misalign_fault  out  1  registered sticky misaligned-target flag.

Function
REQ-016 Winner: the lowest-index asserted bit of redir_valid. "Any redirect" means at least one bit of redir_valid is asserted.
REQ-017 Held slot: registered pend_target (XLEN) and pend_idx, gated by redir_pending.
REQ-018 When en=1 and no reset, the next PC is selected in this order:
- A live winner, if none is pending or winner index <= pend_idx: load its target.
- Otherwise, if a redirect is pending: load pend_target.
- Otherwise: pc_out + INC, modulo 2^XLEN.
REQ-019 When en=1, redir_pending clears at the next edge. A losing live redirect is discarded.
REQ-020 When en=0, pc_out holds.
REQ-021 When en=0 and a winner exists, it is captured into the held slot if none is pending or winner index <= pend_idx; otherwise the held slot is unchanged.
REQ-022 Latency: a live redirect with en=1 appears on pc_out one cycle later. A redirect captured during a stall appears one cycle after en returns to 1.
REQ-023 redir_count increments by 1 on each edge where pc_out loads a redirect target (live or held). It saturates at all-ones.
REQ-024 pc_valid is 0 in the cycle following a reset edge and 1 on every later cycle until the next reset.

Reset
REQ-025 On a reset edge: pc_out=initial_pc, pc_valid=0, redir_pending=0, pend_idx=0, pend_target=0, redir_count=0, misalign_fault=0.
REQ-026 Reset overrides en and redir_valid. A redirect pending at reset is lost.

Configuration
REQ-027 With PC_GEN_ALIGN_CHECK_EN defined: any target loaded into pc_out with bits [1:0] != 0 sets misalign_fault. The target is still loaded unmodified, and the fault stays set until reset.
REQ-028 Without PC_GEN_ALIGN_CHECK_EN: misalign_fault is constant 0 and no check logic is generated. The port remains present.

Structure
REQ-029 Shared package pc_gen_pkg holds:
- The default XLEN, INC and CNT_W constants.
- The source-index enum: SRC_ERET=0, SRC_KERNEL=1, SRC_MISSPRED=2, SRC_PRED=3, SRC_BRANCH=4, SRC_JUMP=5.
REQ-030 One sub-module, pc_gen_prio_sel, is a combinational priority encoder. It takes redir_valid and outputs any-valid and the winner index ($clog2(N_SRC) bits).

Verification
REQ-031 Reset scenario:
- Stimulus: initial_pc=0x1000, reset high for 2 cycles, then en=1 for 3 cycles.
- Required response: pc_valid=0 for one cycle after reset; pc_out follows 0x1000, 0x1004, 0x1008, 0x100C.
REQ-032 Simultaneous redirects:
- Stimulus: redir_valid bits 1 and 4 set (targets 0x8000, 0x2000), en=1.
- Required response: next pc_out=0x8000, redir_count=1.
REQ-033 Stall capture and override:
- Stimulus: en=0; channel 4 redirect to 0x2000, then channel 2 redirect to 0x3000; then en=1.
- Required response: redir_pending=1 throughout the stall, pc_out unchanged, then pc_out=0x3000 and redir_pending=0.
REQ-034 Held versus live priority:
- Stimulus: channel 1 pending (0x4000); en=1 while channel 3 is live (0x5000).
- Required response: pc_out=0x4000; channel 3 discarded.
REQ-035 Wrap and saturation:
- Stimulus: pc_out=0xFFFFFFFC with en=1; separately, redir_count at 0xFFFF when another redirect is applied.
- Required response: next pc_out=0x00000000; redir_count stays 0xFFFF.
REQ-036 Alignment check (PC_GEN_ALIGN_CHECK_EN defined):
- Stimulus: redirect to 0x1002.
- Required response: pc_out=0x1002, misalign_fault=1 and sticky until reset.
